vid_timing_gen: RTL and testbench
=================================

Name: vid_timing_gen

Overview:
- Pixel-timing and scan-out stage directly downstream of the video controller's R/G/B pixel FIFOs.
- Divides clk into a pixel tick and runs horizontal/vertical counters from the controller's cr/h1/h2/v1/v2 register fields.
- Generates hsync/hblank/vsync/vblank, pops one 24-bit pixel per active pixel, and drives registered R/G/B.
- Flags FIFO underflow as a sticky status bit.

Parameters:
- CW, 13, width of all horizontal/vertical position fields and counters.
- PW, 6, width of the pixel divider field pcnt.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  controller enable (cr.en)
- pcnt  in  PW  pixel divider; pixel tick every pcnt+1 clocks
- hsize  in  CW  displayed pixels per line
- hend  in  CW  last pixel index of line (line = hend+1 pixels)
- hsync_start  in  CW  first pixel index with hsync high
- hsync_end  in  CW  first pixel index with hsync low again
- vsize  in  CW  displayed lines per frame
- vend  in  CW  last line index of frame
- vsync_start  in  CW  first line with vsync high
- vsync_end  in  CW  first line with vsync low again
- fifo_data  in  24  {R,G,B} at FIFO head, combinational (valid same cycle)
- fifo_empty  in  1  FIFO empty
- fifo_rd  out  1  pop strobe, one clk per consumed pixel
- hsync, hblank, vsync, vblank  out  1 each  timing outputs
- R, G, B  out  8 each  pixel outputs
- frame_start  out  1  one-clk pulse when counters wrap to (0,0)
- underflow  out  1  sticky: active pixel needed while fifo_empty

Behaviour:
- Reset (async, reset_n low): state IDLE; hc=vc=divcnt=0; hsync=0, hblank=1, vsync=0, vblank=1, R=G=B=0, fifo_rd=0, frame_start=0, underflow=0. Reset mid-frame aborts immediately.
- States:
  - IDLE: counters held at 0, outputs at reset values, underflow cleared. en=1 -> PREFILL.
  - PREFILL: latch all config inputs each clk; wait for fifo_empty=0 -> RUN with hc=vc=divcnt=0.
  - RUN: en=0 on any clk -> IDLE next edge, outputs return to reset values.
- Config shadowing:
  - Config is latched on PREFILL->RUN and at every frame wrap only.
  - Mid-frame input changes take effect from the next frame.
- Pixel tick:
  - tick = RUN & (divcnt == pcnt_l); divcnt increments each clk and clears on tick.
  - pcnt=0 gives a tick every clk.
- Counters, on tick:
  - hc==hend -> hc=0, and vc advances (vc==vend -> vc=0, else vc+1).
  - Otherwise hc+1.
  - All arithmetic is unsigned CW-bit; no other wrap.
- Outputs (registered, updated only on tick edges from pre-increment hc/vc; held between ticks):
  - hblank = (hc >= hsize); vblank = (vc >= vsize).
  - hsync = (hc >= hsync_start) & (hc < hsync_end); vsync likewise on vc. start >= end gives a constant-low sync.
  - active = ~hblank_next & ~vblank_next.
- Pixel pop:
  - fifo_rd = tick & active & ~fifo_empty (combinational).
  - On that edge, {R,G,B} <= fifo_data.
  - On a tick with active & fifo_empty: {R,G,B} <= 0, underflow <= 1, no pop.
  - On a blank tick: {R,G,B} <= 0.
- frame_start: registered one-clk pulse on the tick edge where hc==hend & vc==vend.
- Underflow: cleared only by reset or IDLE.
- Latency: pixel (hc,vc) appears on outputs one clk after the tick on which it was evaluated.

Test Plan:
1. Basic timing: pcnt=0, hsize=4, hend=6, hsync 4..5, vsize=2, vend=3, vsync 2..3, FIFO preloaded 8 pixels 0x000001..0x000008 -> line period 7 clks; hblank high 3 of 7 pixels; hsync high 1 pixel at hc=4; 8 fifo_rd pulses per frame; B sequence 1..8; frame_start every 28 clks.
2. Divider: same timing, pcnt=2 -> ticks every 3 clks; outputs stable 3 clks each; line = 21 clks; fifo_rd exactly 1 clk wide.
3. Underflow: only 5 pixels loaded in scenario-1 timing -> pixels 6..8 output 0x000000, underflow=1 and sticky; en=0 then en=1 clears it.
4. Mid-frame config change: change hsize 4->2 at vc=1 -> current frame keeps 4 active pixels/line; after next frame_start, 2 active/line.
5. PREFILL: en=1 with empty FIFO for 10 clks -> hblank/vblank stay 1, no fifo_rd; first write -> RUN; first pixel on outputs within 2 clks.
6. Reset mid-frame: reset_n low at hc=3, vc=1 -> same cycle all outputs at reset values; after release with en=1, timing restarts at (0,0) via PREFILL.

Source files
------------

// File: rtl/vid_timing_gen.sv
// Video timing generator: pixel-clock divider, h/v scan counters and registered
// R/G/B scan-out from the pixel FIFO, with timing config shadowed per frame.
module vid_timing_gen #(
    parameter int CW = 13,
    parameter int PW = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic [PW-1:0] pcnt,
    input  logic [CW-1:0] hsize,
    input  logic [CW-1:0] hend,
    input  logic [CW-1:0] hsync_start,
    input  logic [CW-1:0] hsync_end,
    input  logic [CW-1:0] vsize,
    input  logic [CW-1:0] vend,
    input  logic [CW-1:0] vsync_start,
    input  logic [CW-1:0] vsync_end,
    input  logic [23:0]   fifo_data,
    input  logic          fifo_empty,
    output logic          fifo_rd,
    output logic          hsync,
    output logic          hblank,
    output logic          vsync,
    output logic          vblank,
    output logic [7:0]    R,
    output logic [7:0]    G,
    output logic [7:0]    B,
    output logic          frame_start,
    output logic          underflow
);
    typedef enum logic [1:0] {IDLE, PREFILL, RUN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] hc, vc;
    logic [PW-1:0] divcnt;
    logic [PW-1:0] pcnt_l;
    logic [CW-1:0] hsize_l, hend_l, hss_l, hse_l;
    logic [CW-1:0] vsize_l, vend_l, vss_l, vse_l;
    logic [23:0]   rgb;
    logic          tick, wrap, hblank_nx, vblank_nx, active;

    assign tick      = (state == RUN) && (divcnt == pcnt_l);
    assign wrap      = tick && (hc == hend_l) && (vc == vend_l);
    assign hblank_nx = hc >= hsize_l;
    assign vblank_nx = vc >= vsize_l;
    assign active    = ~hblank_nx & ~vblank_nx;
    assign fifo_rd   = tick & active & ~fifo_empty;
    assign {R, G, B} = rgb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = PREFILL;
            PREFILL: begin
                if (!en)             state_nx = IDLE;
                else if (!fifo_empty) state_nx = RUN;
            end
            RUN:     if (!en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shadow registers track the inputs while waiting for data, then only
    // reload on the frame wrap so a frame never mixes two configurations.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_l  <= '0;
            hsize_l <= '0; hend_l <= '0; hss_l <= '0; hse_l <= '0;
            vsize_l <= '0; vend_l <= '0; vss_l <= '0; vse_l <= '0;
        end else if (state == PREFILL || wrap) begin
            pcnt_l  <= pcnt;
            hsize_l <= hsize; hend_l <= hend; hss_l <= hsync_start; hse_l <= hsync_end;
            vsize_l <= vsize; vend_l <= vend; vss_l <= vsync_start; vse_l <= vsync_end;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hc <= '0; vc <= '0; divcnt <= '0;
            hsync <= 1'b0; hblank <= 1'b1; vsync <= 1'b0; vblank <= 1'b1;
            rgb <= '0; frame_start <= 1'b0; underflow <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (state == RUN && en) begin
                divcnt <= tick ? '0 : divcnt + 1'b1;
                if (tick) begin
                    if (hc == hend_l) begin
                        hc <= '0;
                        vc <= (vc == vend_l) ? '0 : vc + 1'b1;
                    end else begin
                        hc <= hc + 1'b1;
                    end
                    hblank <= hblank_nx;
                    vblank <= vblank_nx;
                    hsync  <= (hc >= hss_l) && (hc < hse_l);
                    vsync  <= (vc >= vss_l) && (vc < vse_l);
                    if (active && !fifo_empty) rgb <= fifo_data;
                    else                       rgb <= '0;
                    if (active && fifo_empty)  underflow <= 1'b1;
                    frame_start <= wrap;
                end
            end else begin
                // Idle, prefill and the RUN->IDLE edge all present a blanked screen.
                hc <= '0; vc <= '0; divcnt <= '0;
                hsync <= 1'b0; hblank <= 1'b1; vsync <= 1'b0; vblank <= 1'b1;
                rgb <= '0;
                if (state == IDLE) underflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: directed scenarios plus randomized configs, checked
// every cycle against a frame-arithmetic model with a queue-backed FIFO.
module tb_vid_timing_gen;
    localparam int CW = 13;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          reset_n, en;
    logic [PW-1:0] pcnt;
    logic [CW-1:0] hsize, hend, hsync_start, hsync_end;
    logic [CW-1:0] vsize, vend, vsync_start, vsync_end;
    logic [23:0]   fifo_data;
    logic          fifo_empty;
    logic          fifo_rd, hsync, hblank, vsync, vblank, frame_start, underflow;
    logic [7:0]    R, G, B;

    vid_timing_gen #(.CW(CW), .PW(PW)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .pcnt(pcnt),
        .hsize(hsize), .hend(hend), .hsync_start(hsync_start), .hsync_end(hsync_end),
        .vsize(vsize), .vend(vend), .vsync_start(vsync_start), .vsync_end(vsync_end),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
        .R(R), .G(G), .B(B), .frame_start(frame_start), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [23:0] q[$];
    logic [23:0] pend[$];
    int          push_pct = 0;
    logic [23:0] pix_ctr = 24'd1;

    // Model: m_t counts clocks since the frame began; tick n happens on clock
    // n*(p+1)+p and addresses pixel (n % line, n / line).
    int   m_mode = 0;
    int   m_t = 0;
    int   c_p = 0, c_hs = 0, c_he = 0, c_hss = 0, c_hse = 0;
    int   c_vs = 0, c_ve = 0, c_vss = 0, c_vse = 0;
    logic e_hs = 1'b0, e_hb = 1'b1, e_vs = 1'b0, e_vb = 1'b1, e_fs = 1'b0, e_uf = 1'b0;
    logic [23:0] e_rgb = 24'h0;
    int   mh, mv;
    logic mtk, mact, mpop;
    logic [23:0] mpx;

    task automatic load_cfg();
        c_p = int'(pcnt); c_hs = int'(hsize); c_he = int'(hend);
        c_hss = int'(hsync_start); c_hse = int'(hsync_end);
        c_vs = int'(vsize); c_ve = int'(vend);
        c_vss = int'(vsync_start); c_vse = int'(vsync_end);
    endtask

    task automatic idle_outs();
        e_hs = 1'b0; e_hb = 1'b1; e_vs = 1'b0; e_vb = 1'b1; e_rgb = 24'h0; e_fs = 1'b0;
    endtask

    function automatic logic is_tick();
        return ((m_t + 1) % (c_p + 1)) == 0;
    endfunction
    function automatic int cur_h();
        return (m_t / (c_p + 1)) % (c_he + 1);
    endfunction
    function automatic int cur_v();
        return (m_t / (c_p + 1)) / (c_he + 1);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_t = 0; idle_outs(); e_uf = 1'b0;
        end else begin
            e_fs = 1'b0;
            case (m_mode)
                0: begin
                    e_uf = 1'b0;
                    if (en) m_mode = 1;
                end
                1: begin
                    load_cfg();
                    if (!en) m_mode = 0;
                    else if (!fifo_empty) begin m_mode = 2; m_t = 0; end
                end
                default: begin
                    mtk  = is_tick();
                    mh   = cur_h();
                    mv   = cur_v();
                    mact = mtk && (mh < c_hs) && (mv < c_vs);
                    mpop = mact && !fifo_empty;
                    mpx  = mpop ? q.pop_front() : 24'h0;
                    if (!en) begin
                        m_mode = 0; m_t = 0; idle_outs();
                    end else if (mtk) begin
                        e_hb  = mh >= c_hs;
                        e_vb  = mv >= c_vs;
                        e_hs  = (mh >= c_hss) && (mh < c_hse);
                        e_vs  = (mv >= c_vss) && (mv < c_vse);
                        e_rgb = mpx;
                        if (mact && !mpop) e_uf = 1'b1;
                        if (mh == c_he && mv == c_ve) begin
                            e_fs = 1'b1; m_t = 0; load_cfg();
                        end else begin
                            m_t++;
                        end
                    end else begin
                        m_t++;
                    end
                end
            endcase
        end
    end

    // FIFO side changes only on the falling edge; outputs are checked just after.
    always @(negedge clk) begin
        logic exp_rd;
        while (pend.size() > 0) q.push_back(pend.pop_front());
        if (push_pct > 0 && int'($urandom_range(99, 0)) < push_pct) begin
            q.push_back(pix_ctr);
            pix_ctr = pix_ctr + 24'd1;
        end
        fifo_empty = (q.size() == 0);
        fifo_data  = fifo_empty ? 24'h0 : q[0];
        #1;
        exp_rd = (m_mode == 2) && is_tick() && (cur_h() < c_hs) && (cur_v() < c_vs) && !fifo_empty;
        chk("hsync", hsync, e_hs);
        chk("hblank", hblank, e_hb);
        chk("vsync", vsync, e_vs);
        chk("vblank", vblank, e_vb);
        chk("rgb", {R, G, B}, e_rgb);
        chk("frame_start", frame_start, e_fs);
        chk("underflow", underflow, e_uf);
        chk("fifo_rd", fifo_rd, exp_rd);
    end

    task automatic set_basic(input int p);
        pcnt = PW'(p); hsize = 4; hend = 6; hsync_start = 4; hsync_end = 5;
        vsize = 2; vend = 3; vsync_start = 2; vsync_end = 3;
    endtask

    // Waits for a frame_start, then measures the following frame's length and pops.
    task automatic measure_frame(input int exp_cyc, input int exp_rds, input string tag);
        int  c, r;
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk); #2;
            if (frame_start) begin ok = 1'b1; break; end
        end
        chk({tag, "_first_fs"}, ok, 1'b1);
        c = 0; r = 0; ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk); #2;
            c++;
            if (fifo_rd) r++;
            if (frame_start) begin ok = 1'b1; break; end
        end
        chk({tag, "_second_fs"}, ok, 1'b1);
        chk({tag, "_period"}, c, exp_cyc);
        chk({tag, "_pops"}, r, exp_rds);
    endtask

    task automatic stop_run();
        en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int rd_cnt, k;
        reset_n = 1'b0; en = 1'b0; fifo_empty = 1'b1; fifo_data = 24'h0;
        set_basic(0);
        #23;
        chk("rst_hblank", hblank, 1'b1);
        chk("rst_vblank", vblank, 1'b1);
        chk("rst_rgb", {R, G, B}, 24'h0);
        chk("rst_fifo_rd", fifo_rd, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
        reset_n = 1'b1;

        // Basic timing with preloaded pixels 1..8 then a continuous stream.
        @(posedge clk);
        for (int i = 1; i <= 8; i++) pend.push_back(24'(i));
        pix_ctr = 24'd9; push_pct = 100; en = 1'b1;
        measure_frame(28, 8, "basic");

        // Mid-frame hsize change (now in line 1) applies from the next frame.
        repeat (10) @(negedge clk);
        hsize = 2;
        measure_frame(28, 4, "cfg_shadow");
        hsize = 4;

        // Divider.
        stop_run();
        pcnt = 2; en = 1'b1;
        measure_frame(84, 8, "divider");

        // Underflow with only 5 pixels.
        push_pct = 0;
        stop_run();
        q.delete();
        pcnt = 0;
        for (int i = 1; i <= 5; i++) pend.push_back(24'(i));
        en = 1'b1;
        measure_frame(28, 0, "underflow");
        chk("uf_sticky", underflow, 1'b1);
        en = 1'b0;
        repeat (2) @(negedge clk);
        #2 chk("uf_cleared", underflow, 1'b0);

        // Prefill wait with an empty FIFO.
        stop_run();
        q.delete();
        en = 1'b1;
        rd_cnt = 0;
        repeat (10) begin
            @(negedge clk); #2;
            if (fifo_rd) rd_cnt++;
        end
        chk("prefill_hblank", hblank, 1'b1);
        chk("prefill_vblank", vblank, 1'b1);
        chk("prefill_pops", rd_cnt, 0);
        @(posedge clk);
        pend.push_back(24'habcdef);
        for (k = 1; k <= 6; k++) begin
            @(negedge clk); #2;
            if ({R, G, B} == 24'habcdef) break;
        end
        chk("prefill_latency_ok", (k <= 3), 1'b1);

        // Reset in the middle of a frame at (3,1).
        stop_run();
        push_pct = 100; en = 1'b1;
        measure_frame(28, 8, "pre_reset");
        repeat (10) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_hblank", hblank, 1'b1);
        chk("mid_rst_vblank", vblank, 1'b1);
        chk("mid_rst_hsync", hsync, 1'b0);
        chk("mid_rst_rgb", {R, G, B}, 24'h0);
        chk("mid_rst_fifo_rd", fifo_rd, 1'b0);
        #20 reset_n = 1'b1;
        measure_frame(28, 8, "post_reset");

        // Randomized configurations, each with a mid-run config change.
        for (int it = 0; it < 8; it++) begin
            stop_run();
            pcnt        = PW'($urandom_range(3, 0));
            hend        = CW'($urandom_range(10, 2));
            hsize       = CW'($urandom_range(int'(hend) + 2, 0));
            hsync_start = CW'($urandom_range(int'(hend) + 1, 0));
            hsync_end   = CW'($urandom_range(int'(hend) + 1, 0));
            vend        = CW'($urandom_range(5, 1));
            vsize       = CW'($urandom_range(int'(vend) + 2, 0));
            vsync_start = CW'($urandom_range(int'(vend) + 1, 0));
            vsync_end   = CW'($urandom_range(int'(vend) + 1, 0));
            push_pct    = int'($urandom_range(100, 40));
            en = 1'b1;
            repeat (200) @(negedge clk);
            hsize       = CW'($urandom_range(int'(hend) + 1, 0));
            vsync_start = CW'($urandom_range(int'(vend) + 1, 0));
            repeat (200) @(negedge clk);
        end

        stop_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
